// File: rtl/reg_file_ctrl.sv
// Command sequencer for the configuration register file: parses UART opcode/address/data
// frames, drives single-cycle write/read strobes and forwards read data to the TX FIFO.
module reg_file_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int ADDR  = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] RX_P_DATA,
    input  logic             RX_D_VLD,
    input  logic [WIDTH-1:0] RdData,
    input  logic             RdData_VLD,
    input  logic             FIFO_FULL,
    output logic             WrEn,
    output logic             RdEn,
    output logic [ADDR-1:0]  Address,
    output logic [WIDTH-1:0] WrData,
    output logic [WIDTH-1:0] TX_P_DATA,
    output logic             TX_D_VLD,
    output logic             BUSY,
    output logic             CMD_ERR
);

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, BR_ADDR, BR_CNT, RD_REQ, RD_WAIT, TX_PUSH
    } state_t;

    state_t           state_q, state_d;
    logic [ADDR-1:0]  addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] txdata_q, txdata_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wren_q, wren_d;
    logic             rden_q;
    logic             busy_q;
    logic             err_q, err_d;
    logic             addr_ok;
    logic             push;

    assign addr_ok = (RX_P_DATA[WIDTH-1:ADDR] == '0);
    assign push    = (state_q == TX_PUSH) && !FIFO_FULL;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        txdata_d = txdata_q;
        cnt_d    = cnt_q;
        wren_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == WIDTH'(8'hAA))      state_d = WR_ADDR;
                    else if (RX_P_DATA == WIDTH'(8'hBB)) state_d = RD_ADDR;
                    else if (RX_P_DATA == WIDTH'(8'hCC)) state_d = BR_ADDR;
                    else                                 err_d   = 1'b1;
                end
            end
            WR_ADDR, RD_ADDR, BR_ADDR: begin
                if (RX_D_VLD) begin
                    addr_d = RX_P_DATA[ADDR-1:0];
                    if (!addr_ok) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else if (state_q == WR_ADDR) begin
                        state_d = WR_DATA;
                    end else if (state_q == RD_ADDR) begin
                        cnt_d   = WIDTH'(1);
                        state_d = RD_REQ;
                    end else begin
                        state_d = BR_CNT;
                    end
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    wdata_d = RX_P_DATA;
                    wren_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            BR_CNT: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == '0) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = RX_P_DATA;
                        state_d = RD_REQ;
                    end
                end
            end
            // Bytes arriving while a read is in flight are discarded and flagged.
            RD_REQ: begin
                err_d   = RX_D_VLD;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                err_d = RX_D_VLD;
                if (RdData_VLD) begin
                    txdata_d = RdData;
                    state_d  = TX_PUSH;
                end
            end
            TX_PUSH: begin
                err_d = RX_D_VLD;
                if (push) begin
                    cnt_d = cnt_q - WIDTH'(1);
                    if (cnt_q != WIDTH'(1)) begin
                        addr_d  = (addr_q == ADDR'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
                        state_d = RD_REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes and BUSY are registered from the next state so they line up with it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            txdata_q <= '0;
            cnt_q    <= '0;
            wren_q   <= 1'b0;
            rden_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            txdata_q <= txdata_d;
            cnt_q    <= cnt_d;
            wren_q   <= wren_d;
            rden_q   <= (state_d == RD_REQ);
            busy_q   <= (state_d != IDLE);
            err_q    <= err_d;
        end
    end

    assign WrEn      = wren_q;
    assign RdEn      = rden_q;
    assign Address   = addr_q;
    assign WrData    = wdata_q;
    assign TX_P_DATA = txdata_q;
    assign TX_D_VLD  = push;
    assign BUSY      = busy_q;
    assign CMD_ERR   = err_q;

endmodule

// File: doc/reg_file_ctrl.md
# reg_file_ctrl

Command sequencer that owns the configuration register file's access port. It parses byte-wide command frames arriving from the UART receive path and issues single-cycle write/read strobes to the register file. Read results are pushed into the transmit FIFO, with backpressure honoured. It sits between the RX data-sync output, the register file, and the TX FIFO write port, and is the only master of the register file bus.

## Interface
- WIDTH, 8, data byte and register width
- DEPTH, 16, number of registers in the file
- ADDR, 4, register address width (DEPTH = 2^ADDR)

- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- RX_P_DATA  in  WIDTH  received byte, valid only when RX_D_VLD=1
- RX_D_VLD  in  1  one-cycle pulse per received byte
- RdData  in  WIDTH  register file read data
- RdData_VLD  in  1  register file read-valid, high the cycle after RdEn
- FIFO_FULL  in  1  TX FIFO full; blocks pushes
- WrEn  out  1  register write strobe
- RdEn  out  1  register read strobe
- Address  out  ADDR  register address
- WrData  out  WIDTH  register write data
- TX_P_DATA  out  WIDTH  byte pushed to TX FIFO
- TX_D_VLD  out  1  TX FIFO push strobe
- BUSY  out  1  high whenever state != IDLE
- CMD_ERR  out  1  one-cycle pulse on a malformed or dropped frame

## Operation
- Frames (first byte is the opcode):
  - 0xAA addr data: write
  - 0xBB addr: read
  - 0xCC addr count: burst read of count consecutive registers
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, BR_ADDR, BR_CNT, RD_REQ, RD_WAIT, TX_PUSH.
- IDLE:
  - Opcode 0xAA goes to WR_ADDR, 0xBB to RD_ADDR, 0xCC to BR_ADDR.
  - Any other opcode pulses CMD_ERR and stays in IDLE.
- Address byte:
  - Latched into Address.
  - Bits [WIDTH-1:ADDR] must be 0. Otherwise CMD_ERR pulses and the FSM returns to IDLE with no strobe.
- WR_DATA: on byte receipt, latch WrData, pulse WrEn for one cycle, return to IDLE.
- RD_ADDR: sets remaining count = 1 and goes to RD_REQ.
- BR_CNT:
  - Count 0 pulses CMD_ERR and returns to IDLE.
  - Otherwise latch count (1..255) and go to RD_REQ.
- RD_REQ: RdEn=1 for exactly one cycle, then go to RD_WAIT.
- RD_WAIT:
  - Hold until RdData_VLD=1.
  - Capture RdData into TX_P_DATA, then go to TX_PUSH.
- TX_PUSH:
  - TX_D_VLD = (state==TX_PUSH) && !FIFO_FULL. This is the only combinational output path.
  - On a push, decrement count. If count is nonzero, Address increments mod DEPTH (15 wraps to 0) and the FSM goes to RD_REQ; otherwise it goes to IDLE.
  - While FIFO_FULL=1, stay in TX_PUSH with TX_P_DATA stable.
- RX_D_VLD in RD_REQ, RD_WAIT or TX_PUSH: the byte is dropped, CMD_ERR pulses, and the operation in progress continues unaffected.
- WrEn and RdEn are never high in the same cycle.
- Reset values: all outputs 0, state IDLE, count 0.
- RST high at any edge, including mid-frame or mid-burst, forces IDLE. No further strobes or pushes from the aborted frame.

## Timing
- Write: data byte with RX_D_VLD in cycle N gives WrEn, Address and WrData valid in cycle N+1 only.
- Read: address byte in cycle N.
  - RdEn in cycle N+1.
  - RdData_VLD expected in cycle N+2.
  - TX_D_VLD in cycle N+3 if FIFO_FULL=0.
- Burst: 3 cycles per register (RD_REQ, RD_WAIT, TX_PUSH) with no backpressure. Each FIFO_FULL cycle adds one cycle.
- CMD_ERR is high for the cycle after the offending byte.
- BUSY rises in the cycle after the opcode and falls in the cycle the FSM re-enters IDLE.

## Test plan
- Write: send 0xAA, 0x05, 0x3C -> one WrEn pulse with Address=5, WrData=0x3C; RdEn stays 0; BUSY returns to 0.
- Read: send 0xBB, 0x02, with the file model holding 0x21 -> one RdEn pulse at Address=2, then TX_D_VLD=1 with TX_P_DATA=0x21 exactly 3 cycles after the address byte.
- Burst with wrap: send 0xCC, 0x0E, 0x04 -> reads at addresses 14, 15, 0, 1; exactly 4 pushes, in order.
- Backpressure: hold FIFO_FULL=1 for 5 cycles while in TX_PUSH -> TX_D_VLD stays 0 and TX_P_DATA is stable; exactly one push after release.
- Errors:
  - Opcode 0x55 -> one CMD_ERR pulse, no strobes.
  - 0xBB, 0x1F -> CMD_ERR, IDLE.
  - 0xCC, 0x00, 0x00 -> CMD_ERR.
  - A byte arriving mid-burst -> CMD_ERR; the burst still completes.
- Reset: assert RST for 1 cycle during the 2nd register of a 4-register burst -> all outputs 0 from the next cycle; no further RdEn or TX_D_VLD.
